// File: rtl/antialias_pkg.sv
// Shared constants, types and the saturation helper for the alias-reduction stage.
package antialias_pkg;

  localparam int GRANULE_LEN = 576;
  localparam int SB_LEN      = 18;
  localparam int NUM_SB      = 32;
  localparam int NUM_BFLY    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Q15 butterfly coefficients, rounded to nearest; cs7 would round to 1.0 and is clamped.
  localparam logic signed [15:0] cs [NUM_BFLY] = '{
    16'sd28098, 16'sd28893, 16'sd31117, 16'sd32221,
    16'sd32621, 16'sd32740, 16'sd32765, 16'sd32767
  };
  localparam logic signed [15:0] ca [NUM_BFLY] = '{
    -16'sd16859, -16'sd15458, -16'sd10269, -16'sd5961,
    -16'sd3099,  -16'sd1342,  -16'sd465,   -16'sd121
  };

  localparam logic signed [48:0] SAT_MAX = 49'sh0_0000_7FFF_FFFF;
  localparam logic signed [48:0] SAT_MIN = 49'sh1_FFFF_8000_0000;

  // Floor-shift a Q15 product sum back to sample scale and clamp to 32 bits.
  function automatic logic signed [31:0] sat32(input logic signed [48:0] sum);
    logic signed [48:0] sh;
    sh = sum >>> 15;
    if (sh > SAT_MAX)      return 32'sh7FFF_FFFF;
    else if (sh < SAT_MIN) return 32'sh8000_0000;
    else                   return sh[31:0];
  endfunction

endpackage

// File: rtl/antialias_32bit_if.sv
// Sample stream in/out of the alias-reduction stage.
// Handshake: an input sample transfers on a rising edge where din_v and din_ready
// are both high; upstream holds the sample until then. dout_v is a one-cycle
// strobe per output sample with no downstream backpressure.
interface antialias_32bit_if;
  import antialias_pkg::*;

  logic        window_switching_flag_in;
  logic [1:0]  block_type_in;
  logic        mixed_block_flag_in;
  logic [31:0] ch1_in;
  logic [31:0] ch2_in;
  logic        gr_in;
  logic        din_v;
  logic        din_ready;
  logic [31:0] ch1_out;
  logic [31:0] ch2_out;
  logic        gr_out;
  logic        dout_v;
  state_e      dbg_state;

  modport slave (
    input  window_switching_flag_in, block_type_in, mixed_block_flag_in,
    input  ch1_in, ch2_in, gr_in, din_v,
    output din_ready, ch1_out, ch2_out, gr_out, dout_v, dbg_state
  );

  modport master (
    output window_switching_flag_in, block_type_in, mixed_block_flag_in,
    output ch1_in, ch2_in, gr_in, din_v,
    input  din_ready, ch1_out, ch2_out, gr_out, dout_v, dbg_state
  );
endinterface

// File: rtl/antialias_bfly.sv
// One alias-reduction butterfly: a is the upper-subband tail sample, b the lower-subband head.
module antialias_bfly
  import antialias_pkg::*;
(
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  input  logic        [2:0]  p,
  output logic signed [31:0] lo,
  output logic signed [31:0] hi
);

  logic signed [47:0] a_x, b_x, cs_x, ca_x;
  logic signed [47:0] a_cs, a_ca, b_cs, b_ca;
  logic signed [48:0] lo_sum, hi_sum;

  // Full-precision products and sums, then floor-shift and saturate.
  always_comb begin
    a_x    = {{16{a[31]}}, a};
    b_x    = {{16{b[31]}}, b};
    cs_x   = {{32{cs[p][15]}}, cs[p]};
    ca_x   = {{32{ca[p][15]}}, ca[p]};
    a_cs   = a_x * cs_x;
    a_ca   = a_x * ca_x;
    b_cs   = b_x * cs_x;
    b_ca   = b_x * ca_x;
    lo_sum = {a_cs[47], a_cs} - {b_ca[47], b_ca};
    hi_sum = {b_cs[47], b_cs} + {a_ca[47], a_ca};
    lo     = sat32(lo_sum);
    hi     = sat32(hi_sum);
  end

endmodule

// File: rtl/antialias_32bit.sv
// Streaming MP3 alias reduction: 18-deep delay per channel with in-place butterflies
// at enabled subband boundaries, followed by an 18-cycle end-of-granule flush.
module antialias_32bit
  import antialias_pkg::*;
(
  input logic              clk,
  input logic              rst,
  antialias_32bit_if.slave bus
);

  state_e state, state_nxt;

  logic [4:0] p_cnt;   // position within subband, 0..17
  logic [4:0] sb_cnt;  // subband, 0..31
  logic [4:0] fcnt;    // flush read pointer
  logic [4:0] mirror;  // 17 - p_cnt
  logic       short_q, mixed_q, gr_q;
  logic       acc, last_in, bfly_en;

  logic signed [31:0] sbuf1 [SB_LEN];
  logic signed [31:0] sbuf2 [SB_LEN];
  logic signed [31:0] lo1, hi1, lo2, hi2;
  logic signed [31:0] ch1_q, ch2_q;
  logic               gr_q_out, dout_v_q;

  // Handshake, end-of-granule detect and boundary enable.
  always_comb begin
    acc     = bus.din_v && (state != FLUSH);
    last_in = (sb_cnt == 5'd31) && (p_cnt == 5'd17);
    mirror  = 5'd17 - p_cnt;
    bfly_en = (p_cnt < 5'd8) && (sb_cnt != 5'd0) &&
              (!short_q || (mixed_q && (sb_cnt == 5'd1)));
  end

  antialias_bfly u_bfly1 (
    .a (sbuf1[mirror]),
    .b ($signed(bus.ch1_in)),
    .p (p_cnt[2:0]),
    .lo(lo1),
    .hi(hi1)
  );

  antialias_bfly u_bfly2 (
    .a (sbuf2[mirror]),
    .b ($signed(bus.ch2_in)),
    .p (p_cnt[2:0]),
    .lo(lo2),
    .hi(hi2)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: a granule starts on its first accepted sample and ends after the flush.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc) state_nxt = RUN;
      RUN:     if (acc && last_in) state_nxt = FLUSH;
      FLUSH:   if (fcnt == 5'd17) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counters, mode latch, delay buffers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_cnt    <= '0;
      sb_cnt   <= '0;
      fcnt     <= '0;
      short_q  <= 1'b0;
      mixed_q  <= 1'b0;
      gr_q     <= 1'b0;
      ch1_q    <= '0;
      ch2_q    <= '0;
      gr_q_out <= 1'b0;
      dout_v_q <= 1'b0;
      for (int i = 0; i < SB_LEN; i++) begin
        sbuf1[i] <= '0;
        sbuf2[i] <= '0;
      end
    end else begin
      dout_v_q <= 1'b0;
      if (state == FLUSH) begin
        ch1_q    <= sbuf1[fcnt];
        ch2_q    <= sbuf2[fcnt];
        gr_q_out <= gr_q;
        dout_v_q <= 1'b1;
        fcnt     <= (fcnt == 5'd17) ? 5'd0 : fcnt + 5'd1;
      end else if (acc) begin
        if (state == IDLE) begin
          short_q <= bus.window_switching_flag_in && (bus.block_type_in == 2'd2);
          mixed_q <= bus.mixed_block_flag_in;
          gr_q    <= bus.gr_in;
        end
        // The entry about to be overwritten holds the finished sample idx-18.
        if (sb_cnt != 5'd0) begin
          ch1_q    <= sbuf1[p_cnt];
          ch2_q    <= sbuf2[p_cnt];
          gr_q_out <= gr_q;
          dout_v_q <= 1'b1;
        end
        if (bfly_en) begin
          sbuf1[mirror] <= lo1;
          sbuf2[mirror] <= lo2;
          sbuf1[p_cnt]  <= hi1;
          sbuf2[p_cnt]  <= hi2;
        end else begin
          sbuf1[p_cnt] <= $signed(bus.ch1_in);
          sbuf2[p_cnt] <= $signed(bus.ch2_in);
        end
        if (last_in) begin
          p_cnt  <= '0;
          sb_cnt <= '0;
          fcnt   <= '0;
        end else if (p_cnt == 5'd17) begin
          p_cnt  <= '0;
          sb_cnt <= sb_cnt + 5'd1;
        end else begin
          p_cnt <= p_cnt + 5'd1;
        end
      end
    end
  end

  assign bus.din_ready = (state != FLUSH);
  assign bus.ch1_out   = ch1_q;
  assign bus.ch2_out   = ch2_q;
  assign bus.gr_out    = gr_q_out;
  assign bus.dout_v    = dout_v_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_antialias_32bit.sv
// Bench for antialias_32bit: directed granules, expected outputs queued per granule,
// monitor compares every dout_v strobe in order.
module tb_antialias_32bit;
  import antialias_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  antialias_32bit_if bus();

  antialias_32bit dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int low_run  = 0;

  logic [64:0] exp_q[$];
  logic [64:0] mon_e;
  logic [31:0] in1 [576];
  logic [31:0] in2 [576];
  logic [31:0] e1  [576];
  logic [31:0] e2  [576];

  int ref_cs [8] = '{28098, 28893, 31117, 32221, 32621, 32740, 32765, 32767};
  int ref_ca [8] = '{-16859, -15458, -10269, -5961, -3099, -1342, -465, -121};

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_sat(input longint s);
    longint v;
    v = s >>> 15;
    if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (v < -64'sd2147483648) return 32'h8000_0000;
    return v[31:0];
  endfunction

  task automatic bfly_ref(input logic [31:0] a_raw, input logic [31:0] b_raw, input int k,
                          output logic [31:0] lo, output logic [31:0] hi);
    longint a, b;
    a  = longint'($signed(a_raw));
    b  = longint'($signed(b_raw));
    lo = ref_sat(a * ref_cs[k] - b * ref_ca[k]);
    hi = ref_sat(b * ref_cs[k] + a * ref_ca[k]);
  endtask

  task automatic build_expected(input bit sh, input bit mx);
    int lo_i, hi_i;
    for (int i = 0; i < 576; i++) begin
      e1[i] = in1[i];
      e2[i] = in2[i];
    end
    for (int sb = 1; sb < 32; sb++) begin
      if (!sh || (mx && sb == 1)) begin
        for (int k = 0; k < 8; k++) begin
          lo_i = 18 * sb - 1 - k;
          hi_i = 18 * sb + k;
          bfly_ref(in1[lo_i], in1[hi_i], k, e1[lo_i], e1[hi_i]);
          bfly_ref(in2[lo_i], in2[hi_i], k, e2[lo_i], e2[hi_i]);
        end
      end
    end
  endtask

  task automatic push_expected(input bit gr);
    for (int i = 0; i < 576; i++) exp_q.push_back({gr, e1[i], e2[i]});
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 576; i++) begin
      in1[i] = '0;
      in2[i] = '0;
    end
  endtask

  task automatic random_inputs();
    for (int i = 0; i < 576; i++) begin
      in1[i] = $urandom();
      in2[i] = $urandom();
    end
  endtask

  // ---------------- driver ----------------
  // Enters and returns on a falling edge; on return the sample has been accepted.
  task automatic drive_sample(input logic [31:0] d1, input logic [31:0] d2, input int gap);
    int waited;
    for (int g = 0; g < gap; g++) begin
      bus.din_v = 1'b0;
      @(negedge clk);
    end
    bus.din_v  = 1'b1;
    bus.ch1_in = d1;
    bus.ch2_in = d2;
    waited = 0;
    while (bus.din_ready !== 1'b1 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 64) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout got=%0d exp=<64", waited);
    end
    @(negedge clk);
  endtask

  task automatic run_granule(input bit gr, input bit ws, input logic [1:0] bt, input bit mx,
                             input bit gaps, input int n);
    int gap;
    bus.gr_in                    = gr;
    bus.window_switching_flag_in = ws;
    bus.block_type_in            = bt;
    bus.mixed_block_flag_in      = mx;
    for (int i = 0; i < n; i++) begin
      gap = 0;
      if (gaps && $urandom_range(0, 3) == 0) gap = $urandom_range(1, 3);
      drive_sample(in1[i], in2[i], gap);
      if (i == 17) check("no_out_before_idx18", bus.dout_v, 1'b0);
      if (i == 18) check("first_out_after_idx18", bus.dout_v, 1'b1);
    end
  endtask

  task automatic drain();
    int waited;
    bus.din_v = 1'b0;
    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.dout_v === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out got=%h_%h_%h exp=none", bus.gr_out, bus.ch1_out, bus.ch2_out);
        end else begin
          mon_e = exp_q.pop_front();
          check("dout_sample", {bus.gr_out, bus.ch1_out, bus.ch2_out}, mon_e);
        end
      end
      if (bus.din_ready !== 1'b1) begin
        low_run++;
      end else if (low_run != 0) begin
        check("din_ready_low_len", low_run, 18);
        low_run = 0;
      end
    end else begin
      low_run = 0;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.din_v                    = 1'b0;
    bus.ch1_in                   = '0;
    bus.ch2_in                   = '0;
    bus.gr_in                    = 1'b0;
    bus.window_switching_flag_in = 1'b0;
    bus.block_type_in            = 2'd0;
    bus.mixed_block_flag_in      = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dout_v", bus.dout_v, 1'b0);
    check("rst_ch1_out", bus.ch1_out, 32'h0);
    check("rst_ch2_out", bus.ch2_out, 32'h0);
    check("rst_gr_out", bus.gr_out, 1'b0);
    check("rst_din_ready", bus.din_ready, 1'b1);
    check("rst_state", bus.dbg_state, IDLE);
    rst = 1'b0;
    @(negedge clk);

    // Impulse, long block: hand-computed butterfly of 0x00080000 through cs0/ca0.
    clear_inputs();
    in1[17] = 32'h0008_0000;
    for (int i = 0; i < 576; i++) begin
      e1[i] = '0;
      e2[i] = '0;
    end
    e1[17] = 32'h0006_DC20;
    e1[18] = 32'hFFFB_E250;
    push_expected(1'b0);
    run_granule(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 576);
    drain();

    // Pure short: data passes through unchanged.
    random_inputs();
    for (int i = 0; i < 576; i++) begin
      e1[i] = in1[i];
      e2[i] = in2[i];
    end
    push_expected(1'b1);
    run_granule(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 576);
    drain();

    // Mixed: only the sb0/sb1 boundary is processed.
    clear_inputs();
    in1[35] = 32'h0008_0000;
    in2[17] = 32'h0008_0000;
    for (int i = 0; i < 576; i++) begin
      e1[i] = in1[i];
      e2[i] = '0;
    end
    e2[17] = 32'h0006_DC20;
    e2[18] = 32'hFFFB_E250;
    push_expected(1'b0);
    run_granule(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 576);
    drain();

    // Saturation at full-scale inputs on the first boundary.
    clear_inputs();
    in1[17] = 32'h7FFF_FFFF;
    in1[18] = 32'h8000_0000;
    in2[17] = 32'h8000_0000;
    in2[18] = 32'h7FFF_FFFF;
    in2[35] = 32'h7FFF_FFFF;
    in2[36] = 32'h7FFF_FFFF;
    build_expected(1'b0, 1'b0);
    check("model_sat_neg", e1[18], 32'h8000_0000);
    push_expected(1'b1);
    run_granule(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 576);
    drain();

    // Random long data with input gaps, two granules back to back (din_v held across flush).
    random_inputs();
    build_expected(1'b0, 1'b0);
    push_expected(1'b0);
    run_granule(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 576);
    random_inputs();
    build_expected(1'b0, 1'b0);
    push_expected(1'b1);
    run_granule(1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 576);
    drain();

    // Reset mid-granule: partial granule discarded.
    random_inputs();
    build_expected(1'b0, 1'b0);
    push_expected(1'b1);
    run_granule(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 300);
    rst        = 1'b1;
    bus.din_v  = 1'b1;
    bus.ch1_in = in1[300];
    bus.ch2_in = in2[300];
    @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    check("midrst_dout_v", bus.dout_v, 1'b0);
    check("midrst_ch1_out", bus.ch1_out, 32'h0);
    check("midrst_ch2_out", bus.ch2_out, 32'h0);
    check("midrst_gr_out", bus.gr_out, 1'b0);
    check("midrst_state", bus.dbg_state, IDLE);
    rst       = 1'b0;
    bus.din_v = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_no_out", bus.dout_v, 1'b0);

    random_inputs();
    build_expected(1'b0, 1'b0);
    push_expected(1'b0);
    run_granule(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 576);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/antialias_32bit.md
# antialias_32bit

Streaming MP3 alias-reduction stage placed directly after `stereo_32bit`. It consumes that stage's per-sample `ch1_out`/`ch2_out`/`gr_out`/`dout_v` stream, 576 samples per granule in frequency order. It applies the 8 standard butterflies at every enabled subband boundary to both channels in parallel, and emits the result in the same order for the IMDCT stage. An 18-entry buffer per channel gives a fixed latency of 18 accepted samples, plus an 18-cycle end-of-granule flush.

## Interface
- No parameters. Butterfly coefficients are fixed and live in a package.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `window_switching_flag_in` in 1: sampled with the first sample of each granule.
- `block_type_in` in 2: sampled with the first sample of each granule.
- `mixed_block_flag_in` in 1: sampled with the first sample of each granule.
- `ch1_in` in 32: signed sample, channel 1.
- `ch2_in` in 32: signed sample, channel 2.
- `gr_in` in 1: granule tag, sampled with the first sample.
- `din_v` in 1: sample valid. Accepted only when `din_ready`=1.
- `din_ready` out 1: high in IDLE/RUN, low during FLUSH.
- `ch1_out`, `ch2_out` out 32: alias-reduced samples.
- `gr_out` out 1: granule tag of the sample being output.
- `dout_v` out 1: output valid, one-cycle strobe per sample.

## Operation
- Index counter `idx` runs 0..575 over accepted samples.
  - Position `p = idx mod 18`, subband `sb = idx / 18`.
  - Track `p` and `sb` as separate counters; no divider.
- At `idx`=0, latch the mode and `gr_in`:
  - `short` = `window_switching_flag_in` && `block_type_in`==2.
  - Boundary `sb` is enabled when:
    - `!short` and `sb` in 1..31, or
    - `short && mixed_block_flag_in` and `sb`==1.
  - Pure short blocks: no butterflies; the data only passes through the delay.
- Per accepted sample, each channel independently (`b` = input sample, `buf[18]` = the channel's buffer):
  - Output: if `idx` ≥ 18, emit old `buf[p]` (final value of sample `idx-18`).
  - If `p` < 8 and the boundary is enabled:
    - `a = buf[17-p]`.
    - `buf[17-p] = sat(a*cs[p] - b*ca[p])`.
    - `buf[p] = sat(b*cs[p] + a*ca[p])`.
  - Otherwise `buf[p] = b`.
- Arithmetic:
  - 32×16 signed products.
  - The sum is formed at ≥49 bits, arithmetically shifted right by 15 (floor), then saturated to the signed 32-bit range.
- States:
  - **IDLE**: waiting for `idx`=0 sample; goes to RUN on an accepted sample.
  - **RUN**: on acceptance of `idx`=575, goes to FLUSH with `fcnt`=0.
  - **FLUSH**: emits `buf[fcnt]` for `fcnt` 0..17, one per cycle; returns to IDLE after `fcnt`=17.
- `din_v` may drop mid-granule. The block then stalls with no output and no state change.
- `din_v` is ignored while `din_ready`=0. Upstream must hold the sample.

## Timing
- Outputs are registered.
- `dout_v`/data appear the cycle after the accepting edge of sample `idx` (for `idx` ≥ 18), and on each FLUSH cycle.
- Per granule: exactly 576 `dout_v` pulses, in order.
- `gr_out` holds the latched tag for all outputs of that granule.
- The first input of the next granule may be accepted in the cycle after FLUSH ends (`fcnt`=17 output cycle); no bubble beyond that.
- Reset values:
  - `ch1_out`, `ch2_out` = 0; `gr_out` = 0; `dout_v` = 0; `din_ready` = 1.
  - State IDLE; `idx` = 0; `fcnt` = 0; buffers cleared.
- Reset mid-granule or mid-flush: the partial granule is discarded and no further outputs occur for it. The next accepted sample is `idx`=0.

## Structure
- Package `antialias_pkg`:
  - `cs[8]`, `ca[8]` as signed 16-bit Q15, round-to-nearest of standard values.
  - `cs0`=28098, `ca0`=-16859; `cs7` saturated to 32767.
  - State enum {IDLE, RUN, FLUSH}.
  - Constants `GRANULE_LEN`=576, `SB_LEN`=18.
- Sub-module `antialias_bfly`: combinational butterfly (a, b, p) → (lo, hi), including saturation. Instantiated once per channel.
- The top level holds the counters, FSM and both buffers.

## Test plan
- **Impulse, long block.** `ch1` `idx` 17 = 0x00080000, all else 0 → output `idx` 17 = 0x0006DC20, `idx` 18 = 0xFFFBE250, all other samples 0.
- **Pure short.** `window_switching_flag_in`=1, `block_type_in`=2, `mixed_block_flag_in`=0, random data → output identical to input. 576 `dout_v` pulses; first one the cycle after `idx`=18 is accepted.
- **Mixed block.** Impulse at `idx` 35 (sb1/sb2 boundary) → passes unchanged. Impulse at `idx` 17 → changed as in the first scenario.
- **Saturation.** `idx` 17 = 0x7FFFFFFF, `idx` 18 = 0x80000000, long block → `idx` 18 output saturates to 0x80000000 (negative full scale, no wraparound). Compare all 576 samples against a 64-bit reference model.
- **Stall/backpressure.** Random `din_v` gaps, plus `din_v` held high during FLUSH → no sample lost or duplicated. `din_ready` low for exactly 18 cycles. Two back-to-back granules with `gr_in` 0 then 1 → `gr_out` tags correct.
- **Reset mid-granule.** Assert `rst` at `idx`=300 → `dout_v`=0 next cycle and all outputs 0. The following granule matches the reference model with no leftover buffer content.
